// File: rtl/logip_pkg.sv
// Shared types and command-field helpers for the
// logic-analyser capture sequencer.
package logip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    TRG,
    RD,
    STB,
    GAP
  } cap_state_t;

  localparam int FMAX   = 64;
  localparam int RD_LSB = 0;

  function automatic int dly_lsb(input int cmd_w);
    return cmd_w / 2;
  endfunction

  function automatic logic [FMAX-1:0] fld_mask(input int w);
    return (FMAX'(1) << w) - FMAX'(1);
  endfunction

  function automatic logic [FMAX-1:0] parse_rd_cnt(
    input logic [FMAX-1:0] cmd,
    input int              cmd_w
  );
    return (cmd >> RD_LSB) & fld_mask(cmd_w / 2);
  endfunction

  function automatic logic [FMAX-1:0] parse_dly_cnt(
    input logic [FMAX-1:0] cmd,
    input int              cmd_w
  );
    return (cmd >> dly_lsb(cmd_w)) & fld_mask(cmd_w / 2);
  endfunction

  // field N means N+1 groups of 2**shift samples
  function automatic logic [FMAX-1:0] scale_cnt(
    input logic [FMAX-1:0] field,
    input int              shift
  );
    return (field + FMAX'(1)) << shift;
  endfunction

endpackage

// File: rtl/capture_ptr.sv
// Sample-RAM write/read pointers and
// saturating fill level.
module capture_ptr
  import logip_pkg::*;
#(
  parameter int DEPTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             wr_inc_i,
  input  logic             rd_load_i,
  input  logic             rd_dec_i,
  input  logic             fill_clr_i,
  input  logic             fill_inc_i,
  output logic [DEPTH-1:0] wr_ptr_o,
  output logic [DEPTH-1:0] rd_ptr_o,
  output logic [DEPTH:0]   fill_o
);

  localparam logic [DEPTH:0] FULL = (DEPTH+1)'(1) << DEPTH;

  logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH:0]   fill_q, fill_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (wr_inc_i)
      wr_ptr_d = wr_ptr_q + DEPTH'(1);
    // newest sample sits one below the write pointer
    if (rd_load_i)
      rd_ptr_d = wr_ptr_q - DEPTH'(1);
    else if (rd_dec_i)
      rd_ptr_d = rd_ptr_q - DEPTH'(1);
    if (fill_clr_i)
      fill_d = '0;
    else if (fill_inc_i && fill_q != FULL)
      fill_d = fill_q + (DEPTH+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign fill_o   = fill_q;

endmodule

// File: rtl/capture_ctrl.sv
// Capture/readback sequencer: pre/post-trigger
// sample writes and newest-first readback.
module capture_ctrl
  import logip_pkg::*;
#(
  parameter int CMD_W     = 32,
  parameter int DEPTH     = 5,
  parameter int CNT_SHIFT = 2
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             set_cnt_i,
  input  logic [CMD_W-1:0] cmd_i,
  input  logic             arm_i,
  input  logic             run_i,
  input  logic             abort_i,
  input  logic             stb_i,
  output logic             we_o,
  output logic [DEPTH-1:0] addr_o,
  input  logic             tx_rdy_i,
  output logic             tx_stb_o,
  output logic             tx_sel_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int HW = CMD_W / 2;
  localparam int SW = HW + CNT_SHIFT + 1;

  cap_state_t       state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    n_rd_q, n_rd_d;
  logic [HW-1:0]    rd_fld_q, rd_fld_d;
  logic [HW-1:0]    dly_fld_q, dly_fld_d;

  logic [SW-1:0]    rd_smp;
  logic [SW-1:0]    dly_smp;
  logic [SW-1:0]    fill_ext;

  logic             wr_inc;
  logic             rd_load;
  logic             rd_dec;
  logic             fill_clr;
  logic             fill_inc;
  logic [DEPTH-1:0] wr_ptr;
  logic [DEPTH-1:0] rd_ptr;
  logic [DEPTH:0]   fill;

  capture_ptr #(
    .DEPTH(DEPTH)
  ) u_ptr (
    .clk_i     (clk_i),
    .rst_in    (rst_in),
    .wr_inc_i  (wr_inc),
    .rd_load_i (rd_load),
    .rd_dec_i  (rd_dec),
    .fill_clr_i(fill_clr),
    .fill_inc_i(fill_inc),
    .wr_ptr_o  (wr_ptr),
    .rd_ptr_o  (rd_ptr),
    .fill_o    (fill)
  );

  assign rd_smp   = SW'(scale_cnt(FMAX'(rd_fld_q), CNT_SHIFT));
  assign dly_smp  = SW'(scale_cnt(FMAX'(dly_fld_q), CNT_SHIFT));
  assign fill_ext = SW'(fill);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_rd_d    = n_rd_q;
    rd_fld_d  = rd_fld_q;
    dly_fld_d = dly_fld_q;
    we_o      = 1'b0;
    tx_stb_o  = 1'b0;
    done_o    = 1'b0;
    wr_inc    = 1'b0;
    rd_load   = 1'b0;
    rd_dec    = 1'b0;
    fill_clr  = 1'b0;
    fill_inc  = 1'b0;

    if (set_cnt_i && (state_q == IDLE || state_q == ARMED)) begin
      rd_fld_d  = HW'(parse_rd_cnt(FMAX'(cmd_i), CMD_W));
      dly_fld_d = HW'(parse_dly_cnt(FMAX'(cmd_i), CMD_W));
    end

    if (abort_i) begin
      state_d  = IDLE;
      fill_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm_i) begin
            state_d  = ARMED;
            fill_clr = 1'b1;
          end
        end
        ARMED: begin
          if (stb_i) begin
            we_o     = 1'b1;
            wr_inc   = 1'b1;
            fill_inc = 1'b1;
          end
          if (run_i) begin
            state_d = TRG;
            cnt_d   = '0;
          end
        end
        TRG: begin
          if (cnt_q == dly_smp) begin
            state_d = RD;
            rd_load = 1'b1;
            cnt_d   = '0;
            n_rd_d  = (fill_ext < rd_smp) ? fill_ext : rd_smp;
          end else if (stb_i) begin
            we_o     = 1'b1;
            wr_inc   = 1'b1;
            fill_inc = 1'b1;
            cnt_d    = cnt_q + SW'(1);
          end
        end
        RD: begin
          if (cnt_q == n_rd_q) begin
            state_d = IDLE;
            done_o  = 1'b1;
          end else if (tx_rdy_i) begin
            state_d = STB;
          end
        end
        STB: begin
          tx_stb_o = 1'b1;
          rd_dec   = 1'b1;
          cnt_d    = cnt_q + SW'(1);
          state_d  = GAP;
        end
        // transmitter drops rdy a cycle late; skip it
        GAP: state_d = RD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      n_rd_q    <= '0;
      rd_fld_q  <= '0;
      dly_fld_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_rd_q    <= n_rd_d;
      rd_fld_q  <= rd_fld_d;
      dly_fld_q <= dly_fld_d;
    end
  end

  assign tx_sel_o = (state_q == RD) || (state_q == STB) ||
                    (state_q == GAP);
  assign busy_o   = (state_q != IDLE);
  assign addr_o   = tx_sel_o ? rd_ptr : wr_ptr;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed-vector bench for capture_ctrl
// with hand-computed expectations.
module tb_capture_ctrl;

  localparam int CMD_W = 32;
  localparam int DEPTH = 5;

  logic             clk_i = 1'b0;
  logic             rst_in;
  logic             set_cnt_i;
  logic [CMD_W-1:0] cmd_i;
  logic             arm_i;
  logic             run_i;
  logic             abort_i;
  logic             stb_i;
  logic             we_o;
  logic [DEPTH-1:0] addr_o;
  logic             tx_rdy_i;
  logic             tx_stb_o;
  logic             tx_sel_o;
  logic             busy_o;
  logic             done_o;

  int n_vec = 0;
  int n_err = 0;
  int wr_log[$];
  int tx_log[$];
  int done_cnt = 0;

  capture_ctrl #(
    .CMD_W    (CMD_W),
    .DEPTH    (DEPTH),
    .CNT_SHIFT(2)
  ) dut (
    .clk_i    (clk_i),
    .rst_in   (rst_in),
    .set_cnt_i(set_cnt_i),
    .cmd_i    (cmd_i),
    .arm_i    (arm_i),
    .run_i    (run_i),
    .abort_i  (abort_i),
    .stb_i    (stb_i),
    .we_o     (we_o),
    .addr_o   (addr_o),
    .tx_rdy_i (tx_rdy_i),
    .tx_stb_o (tx_stb_o),
    .tx_sel_o (tx_sel_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (we_o) wr_log.push_back(int'(addr_o));
    if (tx_stb_o) tx_log.push_back(int'(addr_o));
    if (done_o) done_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    wr_log.delete();
    tx_log.delete();
  endtask

  task automatic set_cnt(input int rd, input int dly);
    cmd_i     = {16'(dly), 16'(rd)};
    set_cnt_i = 1'b1;
    tick();
    set_cnt_i = 1'b0;
  endtask

  task automatic arm();
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  task automatic trig();
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
  endtask

  task automatic stbs(input int n);
    stb_i = 1'b1;
    repeat (n) tick();
    stb_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(done_cnt - d0), 1);
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    rst_in    = 1'b0;
    set_cnt_i = 1'b0;
    cmd_i     = '0;
    arm_i     = 1'b0;
    run_i     = 1'b0;
    abort_i   = 1'b0;
    stb_i     = 1'b0;
    tx_rdy_i  = 1'b1;
    repeat (2) tick();
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_we", 32'(we_o), 0);
    chk("rst_addr", 32'(addr_o), 0);
    chk("rst_tx_stb", 32'(tx_stb_o), 0);
    chk("rst_tx_sel", 32'(tx_sel_o), 0);
    chk("rst_done", 32'(done_o), 0);
    rst_in = 1'b1;
    tick();

    // 1: reset mid-TRG
    set_cnt(1, 0);
    arm();
    stbs(5);
    trig();
    chk("t1_in_trg", 32'(busy_o), 1);
    chk("t1_addr_pre", 32'(addr_o), 5);
    #2 rst_in = 1'b0;
    #1;
    chk("t1_async_busy", 32'(busy_o), 0);
    chk("t1_async_addr", 32'(addr_o), 0);
    tick();
    rst_in = 1'b1;
    wr_log.delete();
    arm();
    stbs(1);
    chk("t1_first_addr", 32'(qat(wr_log, 0)), 0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;

    // 2: 20 pre, 4 post, 8 readback
    do_reset();
    set_cnt(1, 0);
    arm();
    stbs(20);
    trig();
    stbs(6);
    wait_done("t2_done", 100);
    chk("t2_wr_n", 32'(wr_log.size()), 24);
    chk("t2_post0", 32'(qat(wr_log, 20)), 20);
    chk("t2_post3", 32'(qat(wr_log, 23)), 23);
    chk("t2_tx_n", 32'(tx_log.size()), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_tx%0d", i), 32'(qat(tx_log, i)), 32'(23 - i));
    chk("t2_idle", 32'(busy_o), 0);

    // 3: fill-limited readback
    do_reset();
    set_cnt(1, 0);
    arm();
    stbs(3);
    trig();
    stbs(4);
    wait_done("t3_done", 100);
    chk("t3_tx_n", 32'(tx_log.size()), 7);
    chk("t3_tx_first", 32'(qat(tx_log, 0)), 6);
    chk("t3_tx_last", 32'(qat(tx_log, 6)), 0);

    // 4: wrap and fill saturation
    do_reset();
    set_cnt(15, 0);
    arm();
    stbs(40);
    chk("t4_wr_wrap", 32'(qat(wr_log, 32)), 0);
    chk("t4_wr_39", 32'(qat(wr_log, 39)), 7);
    trig();
    stbs(4);
    wait_done("t4_done", 300);
    chk("t4_tx_n", 32'(tx_log.size()), 32);
    chk("t4_tx_first", 32'(qat(tx_log, 0)), 11);
    chk("t4_tx_zero", 32'(qat(tx_log, 11)), 0);
    chk("t4_tx_wrap", 32'(qat(tx_log, 12)), 31);
    chk("t4_tx_last", 32'(qat(tx_log, 31)), 12);

    // 5: transmitter back-pressure
    do_reset();
    set_cnt(0, 0);
    arm();
    stbs(4);
    trig();
    tx_rdy_i = 1'b0;
    stbs(4);
    tick();
    chk("t5_rd_sel", 32'(tx_sel_o), 1);
    chk("t5_rd_addr", 32'(addr_o), 7);
    repeat (10) tick();
    chk("t5_hold_addr", 32'(addr_o), 7);
    chk("t5_hold_nostb", 32'(tx_log.size()), 0);
    tx_rdy_i = 1'b1;
    tick();
    chk("t5_stb", 32'(tx_stb_o), 1);
    chk("t5_stb_addr", 32'(addr_o), 7);
    tick();
    chk("t5_gap_stb", 32'(tx_stb_o), 0);
    chk("t5_gap_sel", 32'(tx_sel_o), 1);
    tick();
    chk("t5_rd2_stb", 32'(tx_stb_o), 0);
    tick();
    chk("t5_stb2", 32'(tx_stb_o), 1);
    chk("t5_stb2_addr", 32'(addr_o), 6);
    wait_done("t5_done", 100);
    chk("t5_tx_n", 32'(tx_log.size()), 4);

    // 6a: abort in STB
    do_reset();
    set_cnt(0, 0);
    arm();
    stbs(2);
    trig();
    stbs(4);
    tick();
    tick();
    chk("t6_in_stb", 32'(tx_stb_o), 1);
    abort_i = 1'b1;
    #1;
    chk("t6_abort_stb", 32'(tx_stb_o), 0);
    tick();
    abort_i = 1'b0;
    chk("t6_abort_idle", 32'(busy_o), 0);
    repeat (3) tick();
    chk("t6_abort_nodone", 32'(done_cnt), 4);
    chk("t6_abort_notx", 32'(tx_log.size()), 0);

    // 6b: abort in TRG with a strobe pending
    arm();
    stbs(2);
    trig();
    stbs(1);
    stb_i   = 1'b1;
    abort_i = 1'b1;
    #1;
    chk("t6_trg_abort_we", 32'(we_o), 0);
    tick();
    stb_i   = 1'b0;
    abort_i = 1'b0;
    chk("t6_trg_abort_idle", 32'(busy_o), 0);

    // 6c: set_cnt in RD ignored
    do_reset();
    set_cnt(0, 0);
    arm();
    stbs(8);
    trig();
    stbs(4);
    tick();
    cmd_i     = {16'd0, 16'd7};
    set_cnt_i = 1'b1;
    tick();
    set_cnt_i = 1'b0;
    wait_done("t6_rd_done", 100);
    tx_log.delete();
    arm();
    stbs(8);
    trig();
    stbs(4);
    wait_done("t6_rerun_done", 100);
    chk("t6_rerun_tx_n", 32'(tx_log.size()), 4);

    // 6d: run alone ignored; arm+run arms only
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    chk("t6_run_alone", 32'(busy_o), 0);
    arm_i = 1'b1;
    run_i = 1'b1;
    tick();
    arm_i = 1'b0;
    run_i = 1'b0;
    chk("t6_armrun_busy", 32'(busy_o), 1);
    stbs(6);
    tick();
    chk("t6_armrun_armed", 32'(tx_sel_o), 0);
    chk("t6_armrun_busy2", 32'(busy_o), 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
